pipeline_control: RTL and testbench

//  Y86-64 pipeline hazard/exception controller: drives stall/bubble for the F, D, E, M and W pipeline

---
 rtl/y86_pkg.sv | 35 +++
 rtl/pipe_perf_counters.sv | 35 +++
 rtl/pipeline_control.sv | 169 ++++++++++++++++
 tb/tb_pipeline_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (icodes, register ids, status codes) and the controller state type.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctl_state;

  // A status that must stop the machine once it reaches writeback.
  function automatic logic is_exc(input logic [2:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/pipe_perf_counters.sv
// Bank of N saturating event counters; each lane counts one cycle per asserted inc bit while en is high.
module pipe_perf_counters #(
  parameter int CNT_W = 32,
  parameter int N     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [N-1:0]              inc,
  output logic [N-1:0][CNT_W-1:0]   cnt
);

  logic [N-1:0][CNT_W-1:0] cnt_q;
  logic [N-1:0][CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (en && inc[i] && !(&cnt_q[i])) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_control.sv
// Y86-64 hazard/exception controller with RUN/DRAIN/HALTED sequencing.
// Optional PIPE_PERF_CNT_EN adds stall/bubble/mispredict/ret event counters.
module pipeline_control
  import y86_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] retire_cnt
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam int DCW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ctl_state         state_q, state_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [2:0]       final_stat_q, final_stat_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic load_use, ret_in, mispred, m_exc, w_exc;

  always_comb begin
    load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_in   = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    mispred  = (E_icode == IJXX) && !e_Cnd;
    m_exc    = is_exc(m_stat);
    w_exc    = is_exc(W_stat);
  end

  // Stage-register controls; reset flushes, HALTED freezes, otherwise hazard equations.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    if (!rst_n) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      F_stall  = load_use | ret_in;
      // A mispredict squashes D, so holding it would be pointless.
      D_stall  = load_use & ~mispred;
      D_bubble = mispred | (~load_use & ret_in);
      E_bubble = mispred | load_use;
      M_bubble = m_exc | w_exc;
      W_stall  = w_exc;
      set_cc   = (state_q == RUN) && (E_icode == IOPQ) && !m_exc && !w_exc;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    final_stat_d = final_stat_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      RUN: begin
        if (w_exc) begin
          state_d      = HALTED;
          final_stat_d = W_stat;
        end else if (m_exc) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        // Watchdog: a faulting instruction that never reaches W is reported as ADR.
        if (w_exc) begin
          state_d      = HALTED;
          final_stat_d = W_stat;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d      = HALTED;
          final_stat_d = SADR;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
    if ((state_q != HALTED) && (W_stat == SAOK) && !W_stall) begin
      retire_cnt_d = sat_inc(retire_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      drain_cnt_q  <= '0;
      final_stat_q <= SAOK;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      final_stat_q <= final_stat_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign halted     = (state_q == HALTED);
  assign final_stat = final_stat_q;
  assign retire_cnt = retire_cnt_q;

`ifdef PIPE_PERF_CNT_EN
  logic [3:0]            perf_inc;
  logic [3:0][CNT_W-1:0] perf_cnt;

  assign perf_inc = {ret_in & F_stall, mispred, D_bubble | E_bubble, F_stall};

  pipe_perf_counters #(
    .CNT_W (CNT_W),
    .N     (4)
  ) u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != HALTED),
    .inc   (perf_inc),
    .cnt   (perf_cnt)
  );

  assign stall_cnt   = perf_cnt[0];
  assign bubble_cnt  = perf_cnt[1];
  assign mispred_cnt = perf_cnt[2];
  assign ret_cnt     = perf_cnt[3];
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed hazard/exception scenarios plus randomized traffic against a reference model.
module tb_pipeline_control;
  import y86_pkg::*;

  localparam int CNT_W     = 32;
  localparam int DRAIN_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic             e_Cnd;
  logic [2:0]       m_stat, W_stat;
  logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [2:0]       final_stat;
  logic [CNT_W-1:0] retire_cnt;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, mispred_cnt, ret_cnt;
`endif

  pipeline_control #(.CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .final_stat(final_stat), .retire_cnt(retire_cnt)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: architectural view of the controller.
  bit              md_halted, md_draining;
  int              md_drain_cycles;
  logic [2:0]      md_final;
  longint unsigned md_retired;

  function automatic bit stat_exc(input logic [2:0] s);
    return s inside {3'd2, 3'd3, 3'd4};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit lu, ri, mp;
    logic ef, eds, edb, eeb, emb, ews, ecc;
    lu = (E_icode inside {4'h5, 4'hB}) && (E_dstM != 4'hF) && (E_dstM == d_srcA || E_dstM == d_srcB);
    ri = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mp = (E_icode == 4'h7) && !e_Cnd;
    if (!rst_n) begin
      {ef, eds, edb, eeb, emb, ews, ecc} = 7'b0011100;
    end else if (md_halted) begin
      {ef, eds, edb, eeb, emb, ews, ecc} = 7'b1101110;
    end else begin
      ef  = lu | ri;
      eds = lu & !mp;
      edb = mp | (ri & !lu);
      eeb = mp | lu;
      emb = stat_exc(m_stat) | stat_exc(W_stat);
      ews = stat_exc(W_stat);
      ecc = !md_draining && (E_icode == 4'h6) && !stat_exc(m_stat) && !stat_exc(W_stat);
    end
    check("F_stall", 64'(F_stall), 64'(ef));
    check("D_stall", 64'(D_stall), 64'(eds));
    check("D_bubble", 64'(D_bubble), 64'(edb));
    check("E_bubble", 64'(E_bubble), 64'(eeb));
    check("M_bubble", 64'(M_bubble), 64'(emb));
    check("W_stall", 64'(W_stall), 64'(ews));
    check("set_cc", 64'(set_cc), 64'(ecc));
    check("halted", 64'(halted), 64'(md_halted));
    check("final_stat", 64'(final_stat), 64'(md_final));
    check("retire_cnt", 64'(retire_cnt), md_retired);
  endtask

  task automatic model_reset();
    md_halted = 0; md_draining = 0; md_drain_cycles = 0; md_final = 3'd1; md_retired = 0;
  endtask

  task automatic model_clock();
    if (!rst_n) begin
      model_reset();
    end else if (!md_halted) begin
      if (W_stat == 3'd1) md_retired++;
      if (stat_exc(W_stat)) begin
        md_halted = 1; md_draining = 0; md_final = W_stat;
      end else if (md_draining) begin
        md_drain_cycles++;
        if (md_drain_cycles == DRAIN_MAX) begin
          md_halted = 1; md_draining = 0; md_final = 3'd3;
        end
      end else if (stat_exc(m_stat)) begin
        md_draining = 1; md_drain_cycles = 0;
      end
    end
  endtask

  // Inputs are applied at negedge; check mid low phase, then advance one clock.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    D_icode = INOP; E_icode = INOP; M_icode = INOP;
    d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE;
    e_Cnd = 1'b1; m_stat = SAOK; W_stat = SAOK;
  endtask

  function automatic logic [2:0] rand_stat(input int exc_pct);
    if (int'($urandom_range(0, 99)) < exc_pct) return 3'($urandom_range(2, 4));
    return 3'd1;
  endfunction

  task automatic rand_inputs(input int exc_pct);
    D_icode = 4'($urandom_range(0, 11));
    E_icode = 4'($urandom_range(0, 11));
    M_icode = 4'($urandom_range(0, 11));
    E_dstM  = 4'($urandom_range(0, 15));
    d_srcA  = ($urandom_range(0, 3) == 0) ? E_dstM : 4'($urandom_range(0, 15));
    d_srcB  = 4'($urandom_range(0, 15));
    e_Cnd   = 1'($urandom_range(0, 1));
    m_stat  = rand_stat(exc_pct);
    W_stat  = rand_stat(exc_pct);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset flush
    cycle();
    cycle();
    rst_n = 1'b1;

    // Load-use
    E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
    cycle();
    idle();
    cycle();

    // Ret walking through D, E, M; then ret combined with load-use
    D_icode = IRET; cycle();
    D_icode = INOP; E_icode = IRET; cycle();
    E_icode = INOP; M_icode = IRET; cycle();
    idle();
    D_icode = IRET; E_icode = IPOPQ; E_dstM = 4'd5; d_srcB = 4'd5;
    cycle();
    idle();

    // Mispredict taken / not taken; then a CC-setting op
    E_icode = IJXX; e_Cnd = 1'b0; cycle();
    e_Cnd = 1'b1; cycle();
    E_icode = IOPQ; cycle();

    // Random traffic without exceptions
    for (int i = 0; i < 200; i++) begin
      rand_inputs(0);
      cycle();
    end

    // Exception: ADR leaves M, then reaches W
    idle();
    E_icode = IOPQ; m_stat = SADR; cycle();
    m_stat = SAOK; W_stat = SADR; cycle();
    check("exc_halted", 64'(halted), 64'd1);
    check("exc_final", 64'(final_stat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      rand_inputs(0);
      cycle();
    end

    // Reset while halted
    idle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_retire", 64'(retire_cnt), 64'd0);
    cycle();

    // Watchdog: INS in M never arrives at W
    m_stat = SINS; cycle();
    for (int i = 0; i < DRAIN_MAX + 2; i++) begin
      rand_inputs(0);
      cycle();
    end
    check("wd_final", 64'(final_stat), 64'd3);

    // Direct RUN to HALTED on HLT in W
    idle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    W_stat = SHLT; cycle();
    idle(); cycle();
    check("hlt_final", 64'(final_stat), 64'd2);

    // Random traffic with exceptions and occasional resets
    for (int i = 0; i < 600; i++) begin
      rand_inputs(4);
      rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
